// File: rtl/sl_cmd_dispatch.sv
// Far-side command dispatcher: pops {modifier, payload} words, applies them to the
// config/channel/status registers or the SL transmitter, and echoes changes plus RX words back.
module sl_cmd_dispatch #(
   parameter int CONFIG_REG_WIDTH  = 16,
   parameter int STATUS_REG_WIDTH  = 16,
   parameter int CHANNEL_REG_WIDTH = 2,
   parameter int TX_TIMEOUT        = 1024
) (
   input  logic                         pclk,
   input  logic                         preset_n,
   input  logic                         cmd_empty,
   input  logic [33:0]                  cmd_data,
   output logic                         cmd_inc,
   input  logic                         ret_full,
   output logic [33:0]                  ret_data,
   output logic                         ret_inc,
   output logic [31:0]                  tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   input  logic [31:0]                  rx_data,
   input  logic                         rx_valid,
   input  logic                         rx_err,
   output logic [CONFIG_REG_WIDTH-1:0]  config_out,
   output logic [CHANNEL_REG_WIDTH-1:0] channel_out
);

   localparam int CNT_W = $clog2(TX_TIMEOUT);
   localparam logic [1:0] MOD_CONFIG  = 2'd0;
   localparam logic [1:0] MOD_DATA    = 2'd1;
   localparam logic [1:0] MOD_STATUS  = 2'd2;
   localparam logic [1:0] MOD_CHANNEL = 2'd3;

   typedef enum logic [1:0] {IDLE, EXEC, TX_WAIT, PUSH} state_t;

   state_t                         state, state_n;
   logic [33:0]                    cmd_q, cmd_q_n;
   logic                           cmd_inc_n, ret_inc_n, tx_valid_n;
   logic [33:0]                    ret_data_n;
   logic [31:0]                    tx_data_n;
   logic [CONFIG_REG_WIDTH-1:0]    config_r, config_n;
   logic [CHANNEL_REG_WIDTH-1:0]   channel_r, channel_n;
   logic                           tx_busy, tx_busy_n;
   logic                           rx_overflow, rx_overflow_n;
   logic                           rx_error, rx_error_n;
   logic                           tx_timeout, tx_timeout_n;
   logic                           hold_full, hold_full_n;
   logic [31:0]                    hold_word, hold_word_n;
   logic                           dirty, dirty_n, dirty_clr, dirty_force;
   logic [CNT_W-1:0]               cnt, cnt_n;
   logic [4:0]                     status_bits, status_bits_n;
   logic [STATUS_REG_WIDTH-1:0]    status_word;
   logic                           push_now, hold_clear;

   assign status_bits = {tx_timeout, rx_error, rx_overflow, hold_full, tx_busy};
   assign status_word = STATUS_REG_WIDTH'(status_bits);
   assign config_out  = config_r;
   assign channel_out = channel_r;
   assign push_now    = (state == PUSH) && !ret_full;
   assign hold_clear  = push_now && (ret_data[33:32] == MOD_DATA);

   always_comb begin
      state_n       = state;
      cmd_q_n       = cmd_q;
      cmd_inc_n     = 1'b0;
      ret_inc_n     = 1'b0;
      ret_data_n    = ret_data;
      tx_data_n     = tx_data;
      tx_valid_n    = tx_valid;
      config_n      = config_r;
      channel_n     = channel_r;
      tx_busy_n     = tx_busy;
      rx_overflow_n = rx_overflow;
      rx_error_n    = rx_error;
      tx_timeout_n  = tx_timeout;
      hold_full_n   = hold_full;
      hold_word_n   = hold_word;
      cnt_n         = cnt;
      dirty_clr     = 1'b0;
      dirty_force   = 1'b0;

      case (state)
         IDLE: begin
            if (hold_full) begin
               ret_data_n = {MOD_DATA, hold_word};
               state_n    = PUSH;
            end else if (dirty) begin
               // Snapshot taken now; later status changes re-arm dirty for another push.
               ret_data_n = {MOD_STATUS, 32'(status_word)};
               dirty_clr  = 1'b1;
               state_n    = PUSH;
            end else if (!cmd_empty) begin
               cmd_inc_n = 1'b1;
               cmd_q_n   = cmd_data;
               state_n   = EXEC;
            end
         end
         EXEC: begin
            case (cmd_q[33:32])
               MOD_CONFIG: begin
                  config_n   = cmd_q[CONFIG_REG_WIDTH-1:0];
                  ret_data_n = {MOD_CONFIG, 32'(cmd_q[CONFIG_REG_WIDTH-1:0])};
                  state_n    = PUSH;
               end
               MOD_CHANNEL: begin
                  channel_n  = cmd_q[CHANNEL_REG_WIDTH-1:0];
                  ret_data_n = {MOD_CHANNEL, 32'(cmd_q[CHANNEL_REG_WIDTH-1:0])};
                  state_n    = PUSH;
               end
               MOD_STATUS: begin
                  if (cmd_q[2]) rx_overflow_n = 1'b0;
                  if (cmd_q[3]) rx_error_n    = 1'b0;
                  if (cmd_q[4]) tx_timeout_n  = 1'b0;
                  dirty_force = 1'b1;
                  state_n     = IDLE;
               end
               default: begin
                  tx_data_n  = cmd_q[31:0];
                  tx_valid_n = 1'b1;
                  tx_busy_n  = 1'b1;
                  cnt_n      = '0;
                  state_n    = TX_WAIT;
               end
            endcase
         end
         TX_WAIT: begin
            if (tx_valid && tx_ready) begin
               tx_valid_n = 1'b0;
               tx_busy_n  = 1'b0;
               state_n    = IDLE;
            end else if (cnt == CNT_W'(TX_TIMEOUT - 1)) begin
               tx_valid_n   = 1'b0;
               tx_busy_n    = 1'b0;
               tx_timeout_n = 1'b1;
               state_n      = IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            if (push_now) begin
               ret_inc_n = 1'b1;
               state_n   = IDLE;
            end
         end
      endcase

      // RX events come last so a new sticky event beats a W1C in the same cycle.
      if (rx_valid) begin
         if (!hold_full || hold_clear) begin
            hold_word_n = rx_data;
            hold_full_n = 1'b1;
         end else begin
            rx_overflow_n = 1'b1;
         end
      end else if (hold_clear) begin
         hold_full_n = 1'b0;
      end
      if (rx_err) rx_error_n = 1'b1;

      status_bits_n = {tx_timeout_n, rx_error_n, rx_overflow_n, hold_full_n, tx_busy_n};
      dirty_n = (dirty && !dirty_clr) || dirty_force || (status_bits_n != status_bits);
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state       <= IDLE;
         cmd_q       <= '0;
         cmd_inc     <= 1'b0;
         ret_inc     <= 1'b0;
         ret_data    <= '0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         config_r    <= '0;
         channel_r   <= '0;
         tx_busy     <= 1'b0;
         rx_overflow <= 1'b0;
         rx_error    <= 1'b0;
         tx_timeout  <= 1'b0;
         hold_full   <= 1'b0;
         hold_word   <= '0;
         dirty       <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= state_n;
         cmd_q       <= cmd_q_n;
         cmd_inc     <= cmd_inc_n;
         ret_inc     <= ret_inc_n;
         ret_data    <= ret_data_n;
         tx_data     <= tx_data_n;
         tx_valid    <= tx_valid_n;
         config_r    <= config_n;
         channel_r   <= channel_n;
         tx_busy     <= tx_busy_n;
         rx_overflow <= rx_overflow_n;
         rx_error    <= rx_error_n;
         tx_timeout  <= tx_timeout_n;
         hold_full   <= hold_full_n;
         hold_word   <= hold_word_n;
         dirty       <= dirty_n;
         cnt         <= cnt_n;
      end
   end

endmodule

// File: tb/tb_sl_cmd_dispatch.sv
// Bench for sl_cmd_dispatch: FIFO models on both sides, a vector table for register
// commands, and hand-written sequences for TX handshake/timeout, RX overflow and reset.
module tb_sl_cmd_dispatch;

   localparam int TMO = 16;

   logic        pclk = 1'b0;
   logic        preset_n = 1'b0;
   logic        cmd_empty = 1'b1;
   logic [33:0] cmd_data = '0;
   logic        cmd_inc;
   logic        ret_full = 1'b0;
   logic [33:0] ret_data;
   logic        ret_inc;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_err = 1'b0;
   logic [15:0] config_out;
   logic [1:0]  channel_out;

   sl_cmd_dispatch #(.TX_TIMEOUT(TMO)) dut (
      .pclk(pclk), .preset_n(preset_n),
      .cmd_empty(cmd_empty), .cmd_data(cmd_data), .cmd_inc(cmd_inc),
      .ret_full(ret_full), .ret_data(ret_data), .ret_inc(ret_inc),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
      .config_out(config_out), .channel_out(channel_out)
   );

   always #5 pclk = ~pclk;

   logic [33:0] cmd_fifo[$];
   logic [33:0] exp_q[$];
   logic [33:0] ret_log[$];
   int          ret_cyc[$];
   int          cyc = 0;
   int          last_cmd_inc_cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      logic [1:0]  mod;
      logic [31:0] payload;
      logic [15:0] exp_config;
      logic [1:0]  exp_channel;
      logic [33:0] exp_ret;
      int          exp_lat;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // One clock; FIFO side effects of the cycle are recorded at the falling edge.
   task automatic tick();
      @(posedge pclk);
      @(negedge pclk);
      cyc++;
      if (cmd_inc) begin
         if (cmd_fifo.size() == 0) begin
            n_bad++;
            $display("FAIL cmd_inc_on_empty: actual=1 required=0 at cycle %0d", cyc);
         end else begin
            void'(cmd_fifo.pop_front());
            last_cmd_inc_cyc = cyc;
         end
      end
      if (ret_inc) begin
         if (ret_full) begin
            n_bad++;
            $display("FAIL ret_inc_on_full: actual=1 required=0 at cycle %0d", cyc);
         end
         ret_log.push_back(ret_data);
         ret_cyc.push_back(cyc);
      end
      cmd_empty = (cmd_fifo.size() == 0);
      cmd_data  = cmd_empty ? 34'h0 : cmd_fifo[0];
   endtask

   task automatic push_cmd(input logic [1:0] m, input logic [31:0] p);
      cmd_fifo.push_back({m, p});
      cmd_empty = 1'b0;
      cmd_data  = cmd_fifo[0];
   endtask

   task automatic wait_ret(input int n, input int budget);
      int k = 0;
      while (ret_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      if (ret_log.size() < n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ret_wait: actual=%0d pushes required=%0d", ret_log.size(), n);
      end
   endtask

   task automatic rx_strobe(input logic [31:0] d, input logic e);
      rx_data  = d;
      rx_valid = 1'b1;
      rx_err   = e;
      tick();
      rx_valid = 1'b0;
      rx_err   = 1'b0;
   endtask

   // Returns the number of cycles tx_valid stayed high; raises tx_ready in cycle ready_at (0 = never).
   task automatic run_tx(input int ready_at, output int held, output logic [31:0] first_data);
      int k = 0;
      held = 0;
      first_data = '0;
      while (!tx_valid && k < 20) begin
         tick();
         k++;
      end
      if (tx_valid) begin
         first_data = tx_data;
         held = 1;
         while (tx_valid && held <= 4 * TMO) begin
            if (held == ready_at) tx_ready = 1'b1;
            tick();
            if (tx_valid) held++;
         end
         tx_ready = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int          t0;
      int          held;
      logic [31:0] d0;

      vecs[0] = '{2'd0, 32'h0000_00A5, 16'h00A5, 2'd0, {2'd0, 32'h0000_00A5}, 3};
      vecs[1] = '{2'd0, 32'hFFFF_1234, 16'h1234, 2'd0, {2'd0, 32'h0000_1234}, 3};
      vecs[2] = '{2'd3, 32'h0000_0002, 16'h1234, 2'd2, {2'd3, 32'h0000_0002}, 3};
      vecs[3] = '{2'd3, 32'hFFFF_FFFD, 16'h1234, 2'd1, {2'd3, 32'h0000_0001}, 3};
      vecs[4] = '{2'd2, 32'h0000_001F, 16'h1234, 2'd1, {2'd2, 32'h0000_0000}, 4};
      vecs[5] = '{2'd0, 32'h0000_0000, 16'h0000, 2'd1, {2'd0, 32'h0000_0000}, 3};

      // Reset state
      repeat (2) @(negedge pclk);
      check("rst_cmd_inc", cmd_inc, 0);
      check("rst_ret_inc", ret_inc, 0);
      check("rst_ret_data", ret_data, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_config", config_out, 0);
      check("rst_channel", channel_out, 0);
      preset_n = 1'b1;
      repeat (2) tick();

      // Register commands from the table
      for (int i = 0; i < 6; i++) begin
         ret_log.delete();
         ret_cyc.delete();
         t0 = cyc;
         push_cmd(vecs[i].mod, vecs[i].payload);
         wait_ret(1, 20);
         check($sformatf("vec%0d_cmd_lat", i), 34'(last_cmd_inc_cyc - t0), 1);
         if (ret_log.size() > 0) begin
            check($sformatf("vec%0d_ret", i), ret_log[0], vecs[i].exp_ret);
            check($sformatf("vec%0d_ret_lat", i), 34'(ret_cyc[0] - t0), 34'(vecs[i].exp_lat));
         end
         check($sformatf("vec%0d_config", i), config_out, vecs[i].exp_config);
         check($sformatf("vec%0d_channel", i), channel_out, vecs[i].exp_channel);
         repeat (3) tick();
         check($sformatf("vec%0d_push_count", i), ret_log.size(), 1);
      end

      // DATA with tx_ready raised in the fifth valid cycle
      ret_log.delete();
      push_cmd(2'd1, 32'hDEAD_BEEF);
      run_tx(5, held, d0);
      check("tx_data", d0, 32'hDEAD_BEEF);
      check("tx_valid_held", held, 5);
      wait_ret(1, 20);
      repeat (3) tick();
      check("tx_status_count", ret_log.size(), 1);
      if (ret_log.size() > 0) check("tx_status_word", ret_log[0], {2'd2, 32'h0});

      // DATA with tx_ready never raised: timeout, then W1C of the timeout bit
      ret_log.delete();
      push_cmd(2'd1, 32'h1234_5678);
      run_tx(0, held, d0);
      check("tmo_valid_held", held, TMO);
      wait_ret(1, 20);
      if (ret_log.size() > 0) check("tmo_status_word", ret_log[0], {2'd2, 32'h10});
      push_cmd(2'd2, 32'h10);
      wait_ret(2, 20);
      repeat (3) tick();
      check("tmo_w1c_count", ret_log.size(), 2);
      if (ret_log.size() > 1) check("tmo_w1c_word", ret_log[1], {2'd2, 32'h0});

      // Two RX words while the return FIFO is full, plus an rx error strobe
      ret_log.delete();
      ret_full = 1'b1;
      rx_strobe(32'hCAFE_0001, 1'b0);
      repeat (3) tick();
      rx_strobe(32'hCAFE_0002, 1'b1);
      repeat (3) tick();
      check("ovf_no_push_while_full", ret_log.size(), 0);
      ret_full = 1'b0;
      exp_q = '{{2'd1, 32'hCAFE_0001}, {2'd2, 32'h0000_000C}};
      wait_ret(2, 20);
      repeat (3) tick();
      check("ovf_push_count", ret_log.size(), 2);
      for (int i = 0; i < 2 && i < ret_log.size(); i++)
         check($sformatf("ovf_push%0d", i), ret_log[i], exp_q[i]);
      push_cmd(2'd2, 32'h0C);
      wait_ret(3, 20);
      if (ret_log.size() > 2) check("ovf_w1c_word", ret_log[2], {2'd2, 32'h0});

      // Pending command while the RX hold is full: RX and status pushes go first
      ret_log.delete();
      ret_cyc.delete();
      ret_full = 1'b1;
      rx_strobe(32'h0BAD_F00D, 1'b0);
      repeat (2) tick();
      push_cmd(2'd0, 32'h0000_005A);
      repeat (4) tick();
      check("hold_cmd_not_popped", cmd_fifo.size(), 1);
      ret_full = 1'b0;
      exp_q = '{{2'd1, 32'h0BAD_F00D}, {2'd2, 32'h0}, {2'd0, 32'h0000_005A}};
      wait_ret(3, 30);
      for (int i = 0; i < 3 && i < ret_log.size(); i++)
         check($sformatf("hold_push%0d", i), ret_log[i], exp_q[i]);
      if (ret_cyc.size() > 0) check("hold_cmd_after_rx", last_cmd_inc_cyc > ret_cyc[0], 1);
      check("hold_config", config_out, 16'h005A);

      // Reset asserted while waiting on the transmitter
      ret_log.delete();
      push_cmd(2'd1, 32'hA5A5_5A5A);
      t0 = 0;
      while (!tx_valid && t0 < 20) begin
         tick();
         t0++;
      end
      check("rst_tx_valid_before", tx_valid, 1);
      #2 preset_n = 1'b0;
      #1;
      check("rst_mid_tx_valid", tx_valid, 0);
      check("rst_mid_config", config_out, 0);
      check("rst_mid_channel", channel_out, 0);
      check("rst_mid_ret_inc", ret_inc, 0);
      check("rst_mid_cmd_inc", cmd_inc, 0);
      @(negedge pclk);
      repeat (2) tick();
      preset_n = 1'b1;
      repeat (5) tick();
      check("rst_mid_no_push", ret_log.size(), 0);
      check("rst_mid_tx_idle", tx_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
